// File: rtl/gray_sched_pkg.sv
// Shared constants, state encoding and Gray helper for the Gray-coded round-robin scheduler.
package gray_sched_pkg;

  localparam int unsigned PTR_W            = 4;
  localparam int unsigned N_REQ            = 1 << PTR_W;
  localparam int unsigned MAX_HOLD_DEFAULT = 255;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } state_e;

  // Binary index to reflected Gray code.
  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_onehot_dec.sv
// Combinational Gray-to-one-hot decoder with enable; output is all zero when en is low.
module gray_onehot_dec
  import gray_sched_pkg::*;
(
  input  logic [PTR_W-1:0] code,
  input  logic             en,
  output logic [N_REQ-1:0] onehot
);

  logic [PTR_W-1:0] bin;

  // Gray to binary by prefix XOR from the MSB, then shift a single one into place.
  always_comb begin
    bin             = '0;
    bin[PTR_W-1]    = code[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ code[i];
    end
    onehot = en ? (N_REQ'(1) << bin) : '0;
  end

endmodule

// File: rtl/gray_rr_scheduler.sv
// Round-robin scheduler sharing one Gray-coded slot bus among N_REQ requesters.
// Optional grant hold limit and timeout pulse: define GRAY_RR_SCHEDULER_TIMEOUT_EN.
// The release input is named rel because "release" is a SystemVerilog keyword.
module gray_rr_scheduler
  import gray_sched_pkg::*;
`ifdef GRAY_RR_SCHEDULER_TIMEOUT_EN
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  input  logic             rel,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [PTR_W-1:0] grant_gray,
  output logic             busy
`ifdef GRAY_RR_SCHEDULER_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  state_e           state_q, state_d;
  logic [PTR_W-1:0] last_idx_q, last_idx_d;
  logic [PTR_W-1:0] gray_q, gray_d;
  logic             valid_q, valid_d;

  logic             found;
  logic [PTR_W-1:0] win;
  logic             hold_on;  // grant would continue absent a hold limit
  logic             expire;   // hold limit reached this cycle

  // Rotating search starting just after the last winner; last winner is checked last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      logic [PTR_W-1:0] cand;
      cand = last_idx_q + PTR_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign hold_on = (state_q == StGrant) && !rel && req[last_idx_q];

`ifdef GRAY_RR_SCHEDULER_TIMEOUT_EN
  logic [7:0] hold_cnt_q;
  logic       timeout_q;

  assign expire = (hold_cnt_q == 8'(MAX_HOLD - 1));

  // Hold counter sits at zero in IDLE so each grant starts counting from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= (state_q == StGrant) ? hold_cnt_q + 8'd1 : 8'd0;
      timeout_q  <= hold_on && expire;
    end
  end

  assign timeout = timeout_q;
`else
  assign expire = 1'b0;
`endif

  // Next-state: arbitrate in IDLE, hold in GRANT until release, request drop or hold limit.
  always_comb begin
    state_d    = state_q;
    last_idx_d = last_idx_q;
    gray_d     = gray_q;
    valid_d    = valid_q;
    unique case (state_q)
      StIdle: begin
        if (enable && found) begin
          state_d    = StGrant;
          last_idx_d = win;
          gray_d     = bin2gray(win);
          valid_d    = 1'b1;
        end
      end
      StGrant: begin
        if (!hold_on || expire) begin
          state_d = StIdle;
          gray_d  = '0;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        gray_d  = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and grant registers; last_idx resets to the top so the first search starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      last_idx_q <= PTR_W'(N_REQ - 1);
      gray_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_idx_q <= last_idx_d;
      gray_q     <= gray_d;
      valid_q    <= valid_d;
    end
  end

  // One-hot grant derived from the registered Gray code so both always name the same index.
  gray_onehot_dec u_dec (
    .code   (gray_q),
    .en     (valid_q),
    .onehot (grant)
  );

  assign grant_gray  = gray_q;
  assign grant_valid = valid_q;
  assign busy        = (state_q == StGrant);

endmodule

// File: tb/tb_gray_rr_scheduler.sv
// Directed self-checking bench for gray_rr_scheduler with hand-computed expectations.
module tb_gray_rr_scheduler;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] req;
  logic        rel;
  logic [15:0] grant;
  logic        grant_valid;
  logic [3:0]  grant_gray;
  logic        busy;
`ifdef GRAY_RR_SCHEDULER_TIMEOUT_EN
  logic        timeout;
`endif

  int checks = 0;
  int errors = 0;

`ifdef GRAY_RR_SCHEDULER_TIMEOUT_EN
  gray_rr_scheduler #(.MAX_HOLD(4)) dut (
`else
  gray_rr_scheduler dut (
`endif
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .req         (req),
    .rel         (rel),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_gray  (grant_gray),
    .busy        (busy)
`ifdef GRAY_RR_SCHEDULER_TIMEOUT_EN
    ,
    .timeout     (timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the full output set; a live grant implies valid and busy.
  task automatic check_out(input string tag, input logic [15:0] eg, input logic [3:0] egray);
    logic v;
    v = (eg != 16'h0);
    check({tag, ".grant"}, 32'(grant), 32'(eg));
    check({tag, ".gray"}, 32'(grant_gray), 32'(egray));
    check({tag, ".valid"}, 32'(grant_valid), 32'(v));
    check({tag, ".busy"}, 32'(busy), 32'(v));
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    req    = 16'h0;
    rel    = 1'b0;
    #2;
    rst_n  = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    req    = 16'h0;
    rel    = 1'b0;
    #3;
    check_out("reset", 16'h0, 4'b0000);
    rst_n = 1'b1;

    // Single request, then release.
    req = 16'h0001; enable = 1'b1;
    step(); check_out("t1.grant0", 16'h0001, 4'b0000);
    rel = 1'b1;
    step(); check_out("t1.release", 16'h0000, 4'b0000);
    rel = 1'b0; req = 16'h0;
    step(); check_out("t1.idle", 16'h0000, 4'b0000);

    // Round-robin over 0, 7, 15 with a bubble after each release.
    do_reset();
    enable = 1'b1; req = 16'h8081;
    step(); check_out("t2.g0", 16'h0001, 4'b0000);
    rel = 1'b1; step(); check_out("t2.b0", 16'h0000, 4'b0000);
    rel = 1'b0; step(); check_out("t2.g7", 16'h0080, 4'b0100);
    rel = 1'b1; step(); check_out("t2.b1", 16'h0000, 4'b0000);
    rel = 1'b0; step(); check_out("t2.g15", 16'h8000, 4'b1000);
    rel = 1'b1; step(); check_out("t2.b2", 16'h0000, 4'b0000);
    rel = 1'b0; step(); check_out("t2.g0again", 16'h0001, 4'b0000);

    // Wrap-around, exit on request drop, sole-requester regrant.
    do_reset();
    enable = 1'b1; req = 16'h8001;
    step(); check_out("t3.wrap", 16'h0001, 4'b0000);
    req = 16'h8000;
    step(); check_out("t3.drop", 16'h0000, 4'b0000);
    step(); check_out("t3.g15", 16'h8000, 4'b1000);
    rel = 1'b1; step(); check_out("t3.bubble", 16'h0000, 4'b0000);
    rel = 1'b0; step(); check_out("t3.regrant", 16'h8000, 4'b1000);

    // Release asserted in IDLE does not block arbitration.
    do_reset();
    enable = 1'b1; rel = 1'b1; req = 16'h0010;
    step(); check_out("t4.idlerel", 16'h0010, 4'b0110);
    step(); check_out("t4.exit", 16'h0000, 4'b0000);
    rel = 1'b0;

    // Enable drop during a grant: grant runs to completion, nothing new until enable returns.
    do_reset();
    enable = 1'b1; req = 16'h0020;
    step(); check_out("t5.g5", 16'h0020, 4'b0111);
    enable = 1'b0; req = 16'hFFFF;
    step(); check_out("t5.hold1", 16'h0020, 4'b0111);
    step(); check_out("t5.hold2", 16'h0020, 4'b0111);
    rel = 1'b1; step(); check_out("t5.rel", 16'h0000, 4'b0000);
    rel = 1'b0; step(); check_out("t5.dis1", 16'h0000, 4'b0000);
    step(); check_out("t5.dis2", 16'h0000, 4'b0000);
    enable = 1'b1; step(); check_out("t5.g6", 16'h0040, 4'b0101);

    // Asynchronous reset mid-grant, then fresh search from index 0.
    do_reset();
    enable = 1'b1; req = 16'h0400;
    step(); check_out("t6.g10", 16'h0400, 4'b1111);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("t6.async", 16'h0000, 4'b0000);
    #1;
    rst_n = 1'b1;
    enable = 1'b1; req = 16'h0400;
    step(); check_out("t6.after", 16'h0400, 4'b1111);

`ifdef GRAY_RR_SCHEDULER_TIMEOUT_EN
    // Hold limit of 4 grant cycles, then timeout pulse and advance to the next requester.
    do_reset();
    enable = 1'b1; req = 16'h0003;
    for (int c = 0; c < 4; c++) begin
      step(); check_out("t7.hold", 16'h0001, 4'b0000);
      check("t7.to_low", 32'(timeout), 32'd0);
    end
    step(); check_out("t7.forced", 16'h0000, 4'b0000);
    check("t7.to_pulse", 32'(timeout), 32'd1);
    step(); check_out("t7.next", 16'h0002, 4'b0001);
    check("t7.to_clear", 32'(timeout), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
